commit_trace_buffer: RTL

- Parametrised commit-record FIFO between the CPU core's commit point and the trace/difftest host.
- Replaces the single-entry, always-valid commit register.
- Adds depth, valid/ready backpressure, halt latching and retired-instruction and cycle counters.
- The core stalls on in_ready=0; the host drains records at its own rate.

---
 rtl/commit_trace_buffer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: FIFO of commit records that sits between the core's commit point and the
// trace/difftest host. The core stalls while in_ready is low. The host drains records at its own
// rate. The buffer also latches halt and keeps retired-instruction and cycle counters.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   en            global enable; gates pushes and cycle counting (pops are not gated)
//   in_*          committed-instruction record from the core, valid/ready handshake
//   out_*         head record to the host, valid/ready handshake; all fields read 0 when empty
//   out_halt      head record carries the halt instruction
//   halted        sticky flag, set once a halt record has been accepted
//   count         occupancy, 0..DEPTH
//   instret       number of accepted records (wraps)
//   cycles        number of enabled, non-halted cycles (wraps)
module commit_trace_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] HALT_INST = 32'h00100073
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_reg_we,
  input  logic [4:0]               in_reg_wa,
  input  logic [XLEN-1:0]          in_reg_wd,
  input  logic                     in_dmem_we,
  input  logic [XLEN-1:0]          in_dmem_wa,
  input  logic [XLEN-1:0]          in_dmem_wd,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_reg_we,
  output logic [4:0]               out_reg_wa,
  output logic [XLEN-1:0]          out_reg_wd,
  output logic                     out_dmem_we,
  output logic [XLEN-1:0]          out_dmem_wa,
  output logic [XLEN-1:0]          out_dmem_wd,
  output logic                     out_halt,

  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         instret,
  output logic [CNT_W-1:0]         cycles
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef logic [AW-1:0] ptr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            reg_we;
    logic [4:0]      reg_wa;
    logic [XLEN-1:0] reg_wd;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_wa;
    logic [XLEN-1:0] dmem_wd;
    logic            halt;
  } rec_t;

  // Storage is not reset: the head is only ever exposed while count_q != 0, so stale entries
  // are never visible.
  rec_t mem_q [DEPTH];

  ptr_t           wr_ptr_q, wr_ptr_d;
  ptr_t           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           halted_q, halted_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic full;
  logic push;
  logic pop;
  rec_t in_rec;
  rec_t head;

  // Handshake. in_ready depends only on registered state, so there is no combinational path
  // from in_valid or out_ready back to the core.
  always_comb begin
    full      = (count_q == FullCount);
    in_ready  = !full && !halted_q;
    out_valid = (count_q != '0);
    push      = en && in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Record as stored. Writes to x0 are architecturally void, so their enable is dropped here and
  // the host never sees them as register updates.
  always_comb begin
    in_rec         = '0;
    in_rec.pc      = in_pc;
    in_rec.inst    = in_inst;
    in_rec.reg_we  = in_reg_we && (in_reg_wa != 5'd0);
    in_rec.reg_wa  = in_reg_wa;
    in_rec.reg_wd  = in_reg_wd;
    in_rec.dmem_we = in_dmem_we;
    in_rec.dmem_wa = in_dmem_wa;
    in_rec.dmem_wd = in_dmem_wd;
    in_rec.halt    = (in_inst == HALT_INST);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_rec;
    end
  end

  // Next-state logic. DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    halted_d  = halted_q;
    instret_d = instret_q;
    cycles_d  = cycles_q;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + ptr_t'(1);
      instret_d = instret_q + CNT_W'(1);
      if (in_rec.halt) begin
        halted_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Stall cycles still count; only disable and halt freeze the counter.
    if (en && !halted_q) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      halted_q  <= 1'b0;
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      halted_q  <= halted_d;
      instret_q <= instret_d;
      cycles_q  <= cycles_d;
    end
  end

  // Head fields are forced to zero while empty so the host never samples stale data.
  always_comb begin
    head = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  always_comb begin
    out_pc      = head.pc;
    out_inst    = head.inst;
    out_reg_we  = head.reg_we;
    out_reg_wa  = head.reg_wa;
    out_reg_wd  = head.reg_wd;
    out_dmem_we = head.dmem_we;
    out_dmem_wa = head.dmem_wa;
    out_dmem_wd = head.dmem_wd;
    out_halt    = head.halt;
  end

  always_comb begin
    halted  = halted_q;
    count   = count_q;
    instret = instret_q;
    cycles  = cycles_q;
  end

endmodule
